// File: rtl/ex_div.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU, one quotient bit per clock.
// Optional early-out for |dividend| < |divisor| is enabled by defining DIV_EARLY_OUT_EN.
module ex_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StByZero, StOn, StEnd} state_e;

  state_e               r_state, w_state_d;
  logic [CntW-1:0]      r_cnt;
  logic [WIDTH-1:0]     r_rem, r_quo, r_divisor;
  logic                 r_sign_a, r_sign_b, r_signed;
  logic [2*WIDTH-1:0]   r_result, w_result_d;
  logic                 r_ready, w_ready_d;

  logic                 w_start_ok, w_div_zero, w_last;
  logic [WIDTH-1:0]     w_abs_a, w_abs_b;
  logic [WIDTH:0]       w_part;
  logic [WIDTH+1:0]     w_trial;
  logic [WIDTH-1:0]     w_rem_nx, w_quo_nx, w_rem_fix, w_quo_fix;

  assign w_start_ok = start_i & ~annul_i;
  assign w_div_zero = (opdata2_i == '0);
  assign w_last     = (r_cnt == CntLast);
  assign w_abs_a    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign w_abs_b    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

`ifdef DIV_EARLY_OUT_EN
  logic w_early;
  assign w_early = (w_abs_a < w_abs_b);
`endif

  // Partial remainder keeps the shifted-out bit so the compare never overflows.
  assign w_part    = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = {1'b0, w_part} - {2'b00, r_divisor};
  assign w_rem_nx  = w_trial[WIDTH+1] ? w_part[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_nx  = {r_quo[WIDTH-2:0], ~w_trial[WIDTH+1]};
  assign w_quo_fix = (r_signed && (r_sign_a ^ r_sign_b)) ? -w_quo_nx : w_quo_nx;
  assign w_rem_fix = (r_signed && r_sign_a) ? -w_rem_nx : w_rem_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_start_ok) begin
          if (w_div_zero) begin
            w_state_d = StByZero;
          end else begin
`ifdef DIV_EARLY_OUT_EN
            w_state_d = w_early ? StByZero : StOn;
`else
            w_state_d = StOn;
`endif
          end
        end
      end
      StByZero: w_state_d = StEnd;
      StOn: begin
        if (annul_i) begin
          w_state_d = StIdle;
        end else if (w_last) begin
          w_state_d = StEnd;
        end
      end
      StEnd: begin
        if (!start_i) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_ready_d  = 1'b0;
    w_result_d = '0;
    case (r_state)
      StByZero: begin
        w_ready_d  = 1'b1;
        w_result_d = {r_rem, r_quo};
      end
      StOn: begin
        if (!annul_i && w_last) begin
          w_ready_d  = 1'b1;
          w_result_d = {w_rem_fix, w_quo_fix};
        end
      end
      StEnd: begin
        if (start_i) begin
          w_ready_d  = 1'b1;
          w_result_d = r_result;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_signed  <= 1'b0;
      r_result  <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_result <= w_result_d;
      r_ready  <= w_ready_d;
      case (r_state)
        StIdle: begin
          if (w_start_ok) begin
            r_cnt     <= '0;
            r_signed  <= signed_div_i;
            r_sign_a  <= signed_div_i & opdata1_i[WIDTH-1];
            r_sign_b  <= signed_div_i & opdata2_i[WIDTH-1];
            r_divisor <= w_abs_b;
            // BYZERO publishes {r_rem, r_quo} directly on its way to END.
            if (w_div_zero) begin
              r_rem <= '0;
              r_quo <= '0;
            end else begin
`ifdef DIV_EARLY_OUT_EN
              r_rem <= w_early ? opdata1_i : '0;
              r_quo <= w_early ? '0 : w_abs_a;
`else
              r_rem <= '0;
              r_quo <= w_abs_a;
`endif
            end
          end
        end
        StOn: begin
          if (!annul_i) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div: latency, signed/unsigned results, divide-by-zero,
// annul, overflow, mid-division reset and the optional early-out path.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int vectors = 0;
  int miscompares = 0;
  logic seen_ready;

  ex_div #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Starts a division, scrambles the operand inputs after the start edge, and checks
  // ready timing, the result, the hold while start_i stays high, and the release.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [63:0] exp);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    for (int e = 1; e < lat; e++) begin
      tick();
      if (e == 1) begin
        opdata1_i    = ~a;
        opdata2_i    = b ^ 32'h0000_0005;
        signed_div_i = ~sgn;
      end
    end
    check({tag, " ready_early"}, {63'd0, ready_o}, 64'd0);
    tick();
    check({tag, " ready"}, {63'd0, ready_o}, 64'd1);
    check({tag, " result"}, result_o, exp);
    tick();
    check({tag, " ready_hold"}, {63'd0, ready_o}, 64'd1);
    check({tag, " result_hold"}, result_o, exp);
    start_i = 1'b0;
    tick();
    check({tag, " ready_clr"}, {63'd0, ready_o}, 64'd0);
    check({tag, " result_clr"}, result_o, 64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    tick();
    tick();
    check("reset ready", {63'd0, ready_o}, 64'd0);
    check("reset result", result_o, 64'd0);
    rst = 1'b0;
    tick();

    run_div("u7div2", 1'b0, 32'd7, 32'd2, 33, {32'h0000_0001, 32'h0000_0003});
    run_div("sm7div2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("s7divm2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'h0000_0001, 32'hFFFF_FFFD});
    run_div("divzero", 1'b0, 32'h1234_5678, 32'd0, 2, 64'd0);
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0000_0000, 32'h8000_0000});
    run_div("u_max", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, {32'h0000_0000, 32'hFFFF_FFFF});
    run_div("sm100div7", 1'b1, 32'hFFFF_FF9C, 32'd7, 33, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
`ifdef DIV_EARLY_OUT_EN
    run_div("u5div9", 1'b0, 32'd5, 32'd9, 2, {32'h0000_0005, 32'h0000_0000});
    run_div("sm5div9", 1'b1, 32'hFFFF_FFFB, 32'd9, 2, {32'hFFFF_FFFB, 32'h0000_0000});
`else
    run_div("u5div9", 1'b0, 32'd5, 32'd9, 33, {32'h0000_0005, 32'h0000_0000});
    run_div("sm5div9", 1'b1, 32'hFFFF_FFFB, 32'd9, 33, {32'hFFFF_FFFB, 32'h0000_0000});
`endif

    // Annul at edge 10 of 100 / 3; ready must never rise afterwards.
    seen_ready   = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      seen_ready |= ready_o;
    end
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    check("annul ready", {63'd0, ready_o}, 64'd0);
    for (int e = 0; e < 40; e++) begin
      tick();
      seen_ready |= ready_o;
    end
    check("annul never_ready", {63'd0, seen_ready}, 64'd0);
    check("annul result", result_o, 64'd0);
    run_div("u100div3", 1'b0, 32'd100, 32'd3, 33, {32'h0000_0001, 32'h0000_0021});

    // Start annulled in IDLE is ignored.
    start_i = 1'b1;
    annul_i = 1'b1;
    for (int e = 0; e < 3; e++) tick();
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();
    run_div("after_idle_annul", 1'b0, 32'd9, 32'd4, 33, {32'h0000_0001, 32'h0000_0002});

    // Reset at edge 15 of a division.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    for (int e = 1; e <= 14; e++) tick();
    rst = 1'b1;
    tick();
    check("midreset ready", {63'd0, ready_o}, 64'd0);
    check("midreset result", result_o, 64'd0);
    rst     = 1'b0;
    start_i = 1'b0;
    seen_ready = 1'b0;
    for (int e = 0; e < 40; e++) begin
      tick();
      seen_ready |= ready_o;
    end
    check("midreset no_residual", {63'd0, seen_ready}, 64'd0);
    run_div("u1000div7", 1'b0, 32'd1000, 32'd7, 33, {32'h0000_0006, 32'h0000_008E});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Multi-cycle 32/32 integer divider for the execute stage. Serves DIV/DIVU.
- The EX stage drives start_i and holds its stall request while ready_o is low.
- On completion, the EX stage forwards result_o as the hi/lo pair into the EX/MEM pipeline register.
- Restoring radix-2 algorithm, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand width; result_o is 2*WIDTH. Only 32 is verified.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
- opdata1_i  in  32  dividend; sampled with start_i
- opdata2_i  in  32  divisor; sampled with start_i
- start_i  in  1  request; held high by EX until ready_o has been seen
- annul_i  in  1  cancel in-flight division (flush/exception)
- result_o  out  64  {remainder[31:0], quotient[31:0]}
- ready_o  out  1  result_o valid

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - state = IDLE; result_o = 0; ready_o = 0.
  - Internal counter and working registers are cleared.
  - Reset mid-division aborts it with no residual state.
- States: IDLE, BYZERO, ON, END. The state register is updated only on the rising edge.
- IDLE:
  - If start_i = 1 and annul_i = 0 and opdata2_i = 0: go to BYZERO.
  - If start_i = 1 and annul_i = 0 and opdata2_i != 0: go to ON.
    - Latch the absolute values of the operands when signed_div_i = 1; otherwise latch the raw values.
    - Latch the sign flags and signed_div_i.
    - Clear the counter.
  - start_i with annul_i = 1 is ignored.
  - result_o = 0, ready_o = 0.
- BYZERO:
  - Next edge goes to END with result_o = 0.
  - No trap is raised; MIPS leaves the result undefined and the team fixes it at 0.
- ON:
  - If annul_i = 1: go to IDLE on that edge, with ready_o = 0 and result_o = 0. Annul has priority over everything.
  - Otherwise, each edge computes trial = {1'b0, rem} - {1'b0, divisor} (33 bits).
    - trial[32] = 1: rem/quo shift left, inserting quotient bit 0.
    - trial[32] = 0: rem = trial[31:0] shifted, inserting quotient bit 1.
  - Exactly 32 iterations are performed; the counter runs 0..31.
  - The 32nd iteration edge goes to END and applies sign correction:
    - the quotient is negated when signed and the operand signs differ;
    - the remainder is negated when signed and the dividend is negative.
  - result_o and ready_o are registered on that edge.
- END:
  - ready_o = 1; result_o holds its value.
  - Stays in END while start_i = 1.
  - When start_i = 0, the next edge goes to IDLE, with ready_o = 0 and result_o = 0.
  - annul_i has no effect in END; EX drops start_i instead.
- Latency: the start-sampling edge counts as edge 1; ready_o is high after edge 33. Divide-by-zero gives ready_o after edge 2.
- Arithmetic rules:
  - Quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF signed: magnitude 2^31 wraps, giving quotient 0x80000000, remainder 0.
  - Changes to operand inputs after the start edge do not affect the result.
- Back-to-back: a new start is accepted only in IDLE. There is therefore at least one idle cycle between results.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, on an accepted start with a nonzero divisor, an unsigned compare of the latched magnitudes is made.
  - If |dividend| < |divisor|, go directly to END on the next edge.
  - The result is quotient 0, remainder = original opdata1_i (sign preserved). ready_o is high after edge 2.
- Not defined: all nonzero divisors take the full 33-edge path. This is the default build.

Test Plan:
- Unsigned 7 / 2, start held → ready_o after edge 33; result_o = {0x00000001, 0x00000003}. ready_o stays 1 while start_i is held, and clears one edge after start_i drops.
- Signed -7 (0xFFFFFFF9) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / -2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero, 0x12345678 / 0 → ready_o after edge 2; result_o = 0.
- Annul: start 100 / 3, assert annul_i for one cycle at edge 10 → IDLE, ready_o never rises. A new start of 100 / 3 then gives {0x00000001, 0x00000021} at edge 33.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- Reset asserted at edge 15 of a division → result_o = 0, ready_o = 0 next cycle. With DIV_EARLY_OUT_EN, 5 / 9 gives {0x00000005, 0} at edge 2.
